// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the requesters, the arbiter and the shared UART_TX.
// master: arbiter side. slave: requesters + UART_TX side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ack;
  logic [NUM_REQ-1:0]   req_err;
  logic [7:0]           uart_tx_data;
  logic                 uart_tx_ready;
  logic                 uart_tx_done;

  modport master (
    input  req, req_data, uart_tx_done,
    output req_ack, req_err, uart_tx_data, uart_tx_ready
  );

  modport slave (
    output req, req_data, uart_tx_done,
    input  req_ack, req_err, uart_tx_data, uart_tx_ready
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_TX among NUM_REQ byte producers.
// Optional build macro UART_ARB_TAG_EN: each grant sends a tag byte
// {4'hA, 1'b0, grant_id} ahead of the data byte.
//
// state | meaning
// IDLE  | no transfer; arbitrate among pending requests
// LOAD  | byte on uart_tx_data, tx_ready still low
// SEND  | tx_ready raised, timeout counter cleared
// WAIT  | waiting for rising edge of tx_done or timeout
// GAP   | tx_ready low for GAP_CYCLES before next byte/grant
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clock,
  input  logic              reset,
  uart_tx_arbiter_if.master bus,
  output logic              busy,
  output logic [2:0]        grant_id
);
  localparam int                GW       = $clog2(GAP_CYCLES + 1);
  localparam logic [15:0]       TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0]     GAP_LOAD = GW'(GAP_CYCLES - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT, S_GAP} state_t;

  state_t        state;
  logic [2:0]    ptr;
  logic          done_q;
  logic          done_rise;
  logic [15:0]   tmo_cnt;
  logic [GW-1:0] gap_cnt;
  logic          pick_vld;
  logic [2:0]    pick_id;
  logic [7:0]    pick_data;
`ifdef UART_ARB_TAG_EN
  logic          tag_phase;
  logic [7:0]    data_hold;
`endif

  assign done_rise = bus.uart_tx_done & ~done_q;
  assign busy      = (state != S_IDLE);

  // Round-robin pick: smallest distance above ptr (with wrap) wins.
  always_comb begin
    int best;
    int d;
    pick_vld  = 1'b0;
    pick_id   = '0;
    pick_data = '0;
    best      = NUM_REQ;
    d         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = i - int'(ptr) - 1;
      if (d < 0) d = d + NUM_REQ;
      if (bus.req[i] && (d < best)) begin
        best      = d;
        pick_vld  = 1'b1;
        pick_id   = 3'(i);
        pick_data = bus.req_data[8*i +: 8];
      end
    end
  end

  // Sequencer FSM with registered handshake outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= S_IDLE;
      ptr               <= 3'(NUM_REQ - 1);
      done_q            <= 1'b1;
      tmo_cnt           <= '0;
      gap_cnt           <= '0;
      grant_id          <= '0;
      bus.uart_tx_data  <= '0;
      bus.uart_tx_ready <= 1'b0;
      bus.req_ack       <= '0;
      bus.req_err       <= '0;
`ifdef UART_ARB_TAG_EN
      tag_phase         <= 1'b0;
      data_hold         <= '0;
`endif
    end else begin
      done_q      <= bus.uart_tx_done;
      bus.req_ack <= '0;
      bus.req_err <= '0;
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            grant_id <= pick_id;
`ifdef UART_ARB_TAG_EN
            bus.uart_tx_data <= {4'hA, 1'b0, pick_id};
            data_hold        <= pick_data;
            tag_phase        <= 1'b1;
`else
            bus.uart_tx_data <= pick_data;
`endif
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          bus.uart_tx_ready <= 1'b1;
          state             <= S_SEND;
        end
        S_SEND: begin
          tmo_cnt <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (done_rise) begin
            bus.uart_tx_ready <= 1'b0;
            gap_cnt           <= GAP_LOAD;
            state             <= S_GAP;
`ifdef UART_ARB_TAG_EN
            // The tag byte completing is not an ack; the data byte follows.
            if (!tag_phase) begin
              bus.req_ack <= ONE_HOT0 << grant_id;
              ptr         <= grant_id;
            end
`else
            bus.req_ack <= ONE_HOT0 << grant_id;
            ptr         <= grant_id;
`endif
          end else if (tmo_cnt == TMO_LAST) begin
            bus.uart_tx_ready <= 1'b0;
            bus.req_err       <= ONE_HOT0 << grant_id;
            ptr               <= grant_id;
            gap_cnt           <= GAP_LOAD;
            state             <= S_GAP;
`ifdef UART_ARB_TAG_EN
            tag_phase         <= 1'b0;
`endif
          end else if (tmo_cnt != 16'hFFFF) begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
`ifdef UART_ARB_TAG_EN
            if (tag_phase) begin
              bus.uart_tx_data <= data_hold;
              tag_phase        <= 1'b0;
              state            <= S_LOAD;
            end else begin
              state <= S_IDLE;
            end
`else
            state <= S_IDLE;
`endif
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: UART_TX stand-in plus byte/ack/err scoreboards.
module tb_uart_tx_arbiter;
  localparam int NR       = 4;
  localparam int GAP      = 2;
  localparam int TMO      = 100;
  localparam int DONE_DLY = 5;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       busy;
  logic [2:0] grant_id;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(NR), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus), .busy(busy), .grant_id(grant_id)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    logic [2:0] id;
  } exp_t;

  exp_t exp_q[$];
  int   ack_q[$];
  int   err_q[$];
  int   errors = 0;
  int   checks = 0;
  int   n_ack  = 0;
  int   n_errp = 0;

  logic       prev_ready = 1'b0;
  logic [7:0] held       = '0;
  int         u_cnt      = 0;
  bit         u_active   = 1'b0;
  bit         done_en    = 1'b1;

  initial begin
    bus.req          = '0;
    bus.req_data     = '0;
    bus.uart_tx_done = 1'b0;
  end

  // UART_TX stand-in and scoreboard: compare each byte on ready rise, each ack/err pulse.
  always @(negedge clock) begin
    if (!reset) begin
      prev_ready       = 1'b0;
      u_active         = 1'b0;
      u_cnt            = 0;
      bus.uart_tx_done = 1'b0;
    end else begin
      exp_t e;
      logic [NR-1:0] want;
      bus.uart_tx_done = 1'b0;
      if (bus.uart_tx_ready && !prev_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got %02h grant %0d, none expected", bus.uart_tx_data, grant_id);
        end else begin
          e = exp_q.pop_front();
          if (bus.uart_tx_data !== e.data) begin
            errors++;
            $display("FAIL byte_data: got %02h expected %02h", bus.uart_tx_data, e.data);
          end
          checks++;
          if (grant_id !== e.id) begin
            errors++;
            $display("FAIL byte_grant: got %0d expected %0d", grant_id, e.id);
          end
        end
        held     = bus.uart_tx_data;
        u_active = 1'b1;
        u_cnt    = DONE_DLY;
      end else if (bus.uart_tx_ready) begin
        checks++;
        if (bus.uart_tx_data !== held) begin
          errors++;
          $display("FAIL data_hold: got %02h expected %02h", bus.uart_tx_data, held);
        end
      end
      if (u_active) begin
        if (u_cnt == 0) begin
          u_active = 1'b0;
          if (done_en) bus.uart_tx_done = 1'b1;
        end else begin
          u_cnt--;
        end
      end
      prev_ready = bus.uart_tx_ready;
      if (bus.req_ack !== '0) begin
        n_ack++;
        checks++;
        if (ack_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack: got %b, none expected", bus.req_ack);
        end else begin
          want = NR'(1) << ack_q.pop_front();
          if (bus.req_ack !== want) begin
            errors++;
            $display("FAIL ack_pulse: got %b expected %b", bus.req_ack, want);
          end
        end
      end
      if (bus.req_err !== '0) begin
        n_errp++;
        checks++;
        if (err_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_err: got %b, none expected", bus.req_err);
        end else begin
          want = NR'(1) << err_q.pop_front();
          if (bus.req_err !== want) begin
            errors++;
            $display("FAIL err_pulse: got %b expected %b", bus.req_err, want);
          end
        end
      end
    end
  end

  // Queue the bytes a grant to requester id should put on the wire.
  task automatic expect_first(input int id, input logic [7:0] data);
    exp_t e;
`ifdef UART_ARB_TAG_EN
    e.data = {4'hA, 1'b0, 3'(id)};
`else
    e.data = data;
`endif
    e.id = 3'(id);
    exp_q.push_back(e);
  endtask

  task automatic expect_xfer(input int id, input logic [7:0] data);
    exp_t e;
    expect_first(id, data);
`ifdef UART_ARB_TAG_EN
    e.data = data;
    e.id   = 3'(id);
    exp_q.push_back(e);
`endif
    ack_q.push_back(id);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset        = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    done_en      = 1'b1;
    exp_q.delete();
    ack_q.delete();
    err_q.delete();
    repeat (3) @(negedge clock);
    n_ack  = 0;
    n_errp = 0;
    reset  = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (bus.uart_tx_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", bus.uart_tx_ready); end
    checks++; if (bus.uart_tx_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %02h expected 00", bus.uart_tx_data); end
    checks++; if (bus.req_ack !== '0) begin errors++; $display("FAIL rst_ack: got %b expected 0", bus.req_ack); end
    checks++; if (bus.req_err !== '0) begin errors++; $display("FAIL rst_err: got %b expected 0", bus.req_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL rst_grant: got %0d expected 0", grant_id); end
  endtask

  task automatic test_single();
    int lat;
    int gap;
    bit got;
    do_reset();
    bus.req_data[7:0] = 8'h41;
    bus.req[0]        = 1'b1;
    expect_xfer(0, 8'h41);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      lat++;
      if (bus.uart_tx_ready) break;
    end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL single_latency: got %0d clocks expected 2", lat); end
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (bus.req_ack[0]) begin got = 1'b1; bus.req[0] = 1'b0; break; end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL single_ack_wait: got no ack expected ack[0]"); end
    checks++;
    if (bus.uart_tx_ready !== 1'b0) begin errors++; $display("FAIL single_gap_ready: got %b expected 0", bus.uart_tx_ready); end
    gap = 0;
    for (int i = 0; i < 10 && busy; i++) begin
      gap++;
      @(negedge clock);
    end
    checks++;
    if (gap !== GAP) begin errors++; $display("FAIL single_gap_len: got %0d expected %0d", gap, GAP); end
    checks++;
    if (n_ack !== 1) begin errors++; $display("FAIL single_ack_count: got %0d expected 1", n_ack); end
  endtask

  task automatic test_all_four();
    int got;
    do_reset();
    bus.req_data = {8'h4D, 8'h41, 8'h44, 8'h41};
    expect_xfer(0, 8'h41);
    expect_xfer(1, 8'h44);
    expect_xfer(2, 8'h41);
    expect_xfer(3, 8'h4D);
    bus.req = 4'hF;
    got = 0;
    for (int i = 0; i < 600 && got < 4; i++) begin
      @(negedge clock);
      if (bus.req_ack !== '0) begin
        got += $countones(bus.req_ack);
        bus.req = bus.req & ~bus.req_ack;
      end
    end
    repeat (5) @(negedge clock);
    checks++;
    if (got !== 4) begin errors++; $display("FAIL adam_acks: got %0d expected 4", got); end
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL adam_bytes_left: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_rr_continuous();
    int got;
    do_reset();
    bus.req_data[15:8]  = 8'h11;
    bus.req_data[23:16] = 8'h22;
    bus.req[1]          = 1'b1;
    expect_xfer(1, 8'h11);
    for (int i = 0; i < 20 && !bus.uart_tx_ready; i++) @(negedge clock);
    bus.req[2] = 1'b1;
    expect_xfer(2, 8'h22);
    expect_xfer(1, 8'h11);
    expect_xfer(2, 8'h22);
    got = 0;
    for (int i = 0; i < 600 && got < 4; i++) begin
      @(negedge clock);
      if (bus.req_ack !== '0) begin
        got += $countones(bus.req_ack);
        if (got >= 4) bus.req = '0;
      end
    end
    repeat (10) @(negedge clock);
    checks++;
    if (got !== 4) begin errors++; $display("FAIL rr_acks: got %0d expected 4", got); end
    checks++;
    if (ack_q.size() !== 0) begin errors++; $display("FAIL rr_acks_left: got %0d expected 0", ack_q.size()); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_timeout();
    int hi;
    do_reset();
    done_en             = 1'b0;
    bus.req_data[31:24] = 8'h5A;
    bus.req[3]          = 1'b1;
    expect_first(3, 8'h5A);
    err_q.push_back(3);
    for (int i = 0; i < 20 && !bus.uart_tx_ready; i++) @(negedge clock);
    hi = 0;
    for (int i = 0; i < 300 && bus.uart_tx_ready; i++) begin
      hi++;
      @(negedge clock);
    end
    checks++;
    if (hi !== TMO + 1) begin errors++; $display("FAIL tmo_ready_cycles: got %0d expected %0d", hi, TMO + 1); end
    checks++;
    if (bus.req_err !== 4'b1000) begin errors++; $display("FAIL tmo_err: got %b expected 1000", bus.req_err); end
    bus.req = '0;
    for (int i = 0; i < 10 && busy; i++) @(negedge clock);
    repeat (3) @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL tmo_idle: got busy=%b expected 0", busy); end
    checks++;
    if (n_ack !== 0) begin errors++; $display("FAIL tmo_no_ack: got %0d acks expected 0", n_ack); end
    checks++;
    if (n_errp !== 1) begin errors++; $display("FAIL tmo_err_count: got %0d expected 1", n_errp); end
    done_en = 1'b1;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    done_en             = 1'b0;
    bus.req_data[23:16] = 8'h33;
    bus.req[2]          = 1'b1;
    expect_first(2, 8'h33);
    for (int i = 0; i < 20 && !bus.uart_tx_ready; i++) @(negedge clock);
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.uart_tx_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b expected 0", bus.uart_tx_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL midrst_grant: got %0d expected 0", grant_id); end
    checks++; if (bus.req_ack !== '0) begin errors++; $display("FAIL midrst_ack: got %b expected 0", bus.req_ack); end
    bus.req = '0;
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset   = 1'b1;
    done_en = 1'b1;
    repeat (20) @(negedge clock);
    checks++;
    if (n_ack !== 0) begin errors++; $display("FAIL midrst_no_ack: got %0d expected 0", n_ack); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_rr_continuous();
    test_timeout();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule
